// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the instruction fetch stage.
// Drives fetch enable, jump select and jump target. Issues IF/ID and ID/EX
// flush pulses from stall, memory-wait, branch-resolution and halt requests.
// Optional build macro: FETCH_CTRL_PERF_EN builds the saturating stall_cycles
// counter. Without it, stall_cycles is tied to zero.
module fetch_ctrl #(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned XLEN              = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_req,
  input  logic            mem_busy,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic            fetch_en,
  output logic            jump,
  output logic [XLEN-1:0] jpc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            halted,
  output logic [15:0]     stall_cycles
);

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0]      HOLD_INIT  = 4'(RESET_HOLD_CYCLES);
  // Redirect targets are word aligned; the two low bits are dropped.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [1:0]      state_q, state_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            halt_pend_q, halt_pend_d;
  logic            flush_q, flush_d;

  // Next-state decode and combinational fetch-stage controls.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    target_d    = target_q;
    halt_pend_d = halt_pend_q;
    flush_d     = 1'b0;
    fetch_en    = 1'b0;
    jump        = 1'b0;
    case (state_q)
      S_HOLD: begin
        // Requests are ignored until the hold period expires.
        if (hold_cnt_q <= 4'd1) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      S_RUN: begin
        fetch_en = ~(stall_req | mem_busy);
        if (branch_taken) begin
          // A branch outranks stalls and halts; a coincident halt waits
          // until the redirect has been taken.
          target_d    = branch_target & ALIGN_MASK;
          state_d     = S_REDIR;
          flush_d     = 1'b1;
          halt_pend_d = halt_pend_q | halt_req;
        end else if (halt_req) begin
          state_d = S_HALT;
        end
      end
      S_REDIR: begin
        jump     = 1'b1;
        fetch_en = ~mem_busy;
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (!mem_busy) begin
          state_d     = (halt_pend_q | halt_req) ? S_HALT : S_RUN;
          halt_pend_d = 1'b0;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Control state registers; reset discards any pending redirect or halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= HOLD_INIT;
      target_q    <= '0;
      halt_pend_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      target_q    <= target_d;
      halt_pend_q <= halt_pend_d;
      flush_q     <= flush_d;
    end
  end

  assign jpc        = target_q;
  assign flush_ifid = flush_q;
  assign flush_idex = flush_q;
  assign halted     = (state_q == S_HALT);

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] stall_cycles_q;

  // Count RUN cycles in which fetch is held; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else if ((state_q == S_RUN) && !fetch_en && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl (RESET_HOLD_CYCLES=2, XLEN=32).
// Expected outputs are queued as each cycle's stimulus is applied and compared
// when the outputs are sampled on the following falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_req = 1'b0;
  logic        mem_busy = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        fetch_en;
  logic        jump;
  logic [31:0] jpc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        halted;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        fe;
    logic        jmp;
    logic [31:0] jpc;
    logic        fl;
    logic        hlt;
    logic [15:0] sc;
  } exp_t;

  exp_t sb_q[$];

  fetch_ctrl #(.RESET_HOLD_CYCLES(2), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .mem_busy      (mem_busy),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .fetch_en      (fetch_en),
    .jump          (jump),
    .jpc           (jpc),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .halted        (halted),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] perf_exp(input logic [15:0] n);
`ifdef FETCH_CTRL_PERF_EN
    return n;
`else
    return n & 16'h0000;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic fe, input logic jmp,
                         input logic [31:0] ejpc, input logic fl, input logic hlt,
                         input logic [15:0] sc);
    exp_t e;
    e.tag = tag; e.fe = fe; e.jmp = jmp; e.jpc = ejpc;
    e.fl = fl; e.hlt = hlt; e.sc = sc;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".fetch_en"},     32'(fetch_en),     32'(e.fe));
      check_eq({e.tag, ".jump"},         32'(jump),         32'(e.jmp));
      check_eq({e.tag, ".jpc"},          jpc,               e.jpc);
      check_eq({e.tag, ".flush_ifid"},   32'(flush_ifid),   32'(e.fl));
      check_eq({e.tag, ".flush_idex"},   32'(flush_idex),   32'(e.fl));
      check_eq({e.tag, ".halted"},       32'(halted),       32'(e.hlt));
      check_eq({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
    end
  endtask

  // One clock cycle: apply inputs just after the rising edge, queue the
  // expected outputs for that cycle, compare on the falling edge.
  task automatic step(input string tag, input logic r, input logic st, input logic mb,
                      input logic bt, input logic [31:0] tgt, input logic hr, input logic rs,
                      input logic efe, input logic ej, input logic [31:0] ejpc,
                      input logic efl, input logic eh, input logic [15:0] esc);
    @(posedge clk);
    #1;
    rst = r; stall_req = st; mem_busy = mb; branch_taken = bt;
    branch_target = tgt; halt_req = hr; resume = rs;
    sb_push(tag, efe, ej, ejpc, efl, eh, esc);
    @(negedge clk);
    sb_compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with requests present while reset is held.
    step("rst0",  0, 0,0,0,32'h0,        0,0, 0,0,32'h0,0,0,16'h0);
    step("rst1",  0, 0,0,1,32'hFFFF_FFFF,1,1, 0,0,32'h0,0,0,16'h0);
    // Hold period: two disabled cycles after release, requests ignored.
    step("hold0", 1, 0,0,0,32'h0,        0,0, 0,0,32'h0,0,0,16'h0);
    step("hold1", 1, 0,0,1,32'h44,       1,0, 0,0,32'h0,0,0,16'h0);
    step("run0",  1, 0,0,0,32'h0,        0,0, 1,0,32'h0,0,0,16'h0);

    // Branch redirect with target alignment and one-cycle flush.
    step("br_req",   1, 0,0,1,32'h43, 0,0, 1,0,32'h0, 0,0,16'h0);
    step("br_redir", 1, 0,0,0,32'h0,  0,0, 1,1,32'h40,1,0,16'h0);
    step("br_done",  1, 0,0,0,32'h0,  0,0, 1,0,32'h40,0,0,16'h0);

    // Three stalled RUN cycles.
    step("stl1",    1, 1,0,0,32'h0, 0,0, 0,0,32'h40,0,0,perf_exp(16'd0));
    step("stl2",    1, 1,0,0,32'h0, 0,0, 0,0,32'h40,0,0,perf_exp(16'd1));
    step("stl3",    1, 1,0,0,32'h0, 0,0, 0,0,32'h40,0,0,perf_exp(16'd2));
    step("stl_end", 1, 0,0,0,32'h0, 0,0, 1,0,32'h40,0,0,perf_exp(16'd3));

    // Branch and halt together; redirect waits two cycles on memory.
    step("bh_req", 1, 0,0,1,32'h1234_567B,1,0, 1,0,32'h40,       0,0,perf_exp(16'd3));
    step("bh_w1",  1, 0,1,0,32'h0,        0,0, 0,1,32'h1234_5678,1,0,perf_exp(16'd3));
    step("bh_w2",  1, 1,1,1,32'hDEAD_BEEF,0,0, 0,1,32'h1234_5678,0,0,perf_exp(16'd3));
    step("bh_go",  1, 0,0,0,32'h0,        0,0, 1,1,32'h1234_5678,0,0,perf_exp(16'd3));
    step("halt0",  1, 1,0,1,32'h100,      1,0, 0,0,32'h1234_5678,0,1,perf_exp(16'd3));
    step("halt1",  1, 0,0,0,32'h0,        0,1, 0,0,32'h1234_5678,0,1,perf_exp(16'd3));
    step("run_mb", 1, 0,1,0,32'h0,        0,0, 0,0,32'h1234_5678,0,0,perf_exp(16'd3));
    step("run_rs", 1, 0,0,0,32'h0,        0,1, 1,0,32'h1234_5678,0,0,perf_exp(16'd4));
    step("run_ok", 1, 0,0,0,32'h0,        0,0, 1,0,32'h1234_5678,0,0,perf_exp(16'd4));

    // Asynchronous reset in the middle of a redirect with a pending halt.
    step("ar_req",   1, 0,0,1,32'h80,0,0, 1,0,32'h1234_5678,0,0,perf_exp(16'd4));
    step("ar_redir", 1, 0,1,0,32'h0, 1,0, 0,1,32'h80,       1,0,perf_exp(16'd4));
    #2;
    rst = 1'b0;
    sb_push("ar_async", 0,0,32'h0,0,0,16'h0);
    #1;
    sb_compare();
    step("ar_low",  0, 0,1,0,32'h0,0,0, 0,0,32'h0,0,0,16'h0);
    step("ar_h0",   1, 0,0,0,32'h0,0,0, 0,0,32'h0,0,0,16'h0);
    step("ar_h1",   1, 0,0,0,32'h0,0,0, 0,0,32'h0,0,0,16'h0);
    step("ar_run",  1, 0,0,0,32'h0,0,0, 1,0,32'h0,0,0,16'h0);
    step("ar_run2", 1, 0,0,0,32'h0,0,0, 1,0,32'h0,0,0,16'h0);

    // Long stall to bring the counter to 16'hFFFE, then check saturation.
    @(posedge clk);
    #1;
    stall_req = 1'b1;
    repeat (65533) @(posedge clk);
    step("sat1",    1, 1,0,0,32'h0,0,0, 0,0,32'h0,0,0,perf_exp(16'hFFFE));
    step("sat2",    1, 1,0,0,32'h0,0,0, 0,0,32'h0,0,0,perf_exp(16'hFFFF));
    step("sat3",    1, 1,0,0,32'h0,0,0, 0,0,32'h0,0,0,perf_exp(16'hFFFF));
    step("sat4",    1, 1,0,0,32'h0,0,0, 0,0,32'h0,0,0,perf_exp(16'hFFFF));
    step("sat_end", 1, 0,0,0,32'h0,0,0, 1,0,32'h0,0,0,perf_exp(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction fetch stage of the five-stage pipeline. It drives the fetch stage's enable, jump select and jump target from pipeline stall, memory-wait, branch-resolution and halt requests. It also issues flush pulses to the IF/ID and ID/EX pipeline registers. It sits between the hazard/branch logic in decode/execute and the fetch stage.

Parameters:
RESET_HOLD_CYCLES, 2, cycles fetch stays disabled after reset release (valid range 1..15)
XLEN, 32, PC/target width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stall_req  input  1  load-use stall from decode; fetch holds PC
mem_busy  input  1  instruction memory not ready; fetch holds PC
branch_taken  input  1  single-cycle pulse from execute: taken branch or jump resolved
branch_target  input  XLEN  redirect target; valid only with branch_taken
halt_req  input  1  single-cycle pulse: ebreak/debug halt request
resume  input  1  single-cycle pulse: leave HALT
fetch_en  output  1  to fetch enable; PC advances when 1
jump  output  1  to fetch jump select
jpc  output  XLEN  to fetch jump target
flush_ifid  output  1  one-cycle flush of IF/ID register
flush_idex  output  1  one-cycle flush of ID/EX register
halted  output  1  1 while in HALT
stall_cycles  output  16  saturating count of stalled RUN cycles

Behaviour:
- States: HOLD, RUN, REDIRECT, HALT. The state, hold counter, target_q, halt_pend, flush register and stall_cycles are registered. Other outputs are decoded combinationally from state and inputs.
- Reset (rst=0, any time, asynchronous): state=HOLD, hold_cnt=RESET_HOLD_CYCLES, target_q=0, halt_pend=0, stall_cycles=0. Outputs: fetch_en=0, jump=0, jpc=0, flush_ifid=0, flush_idex=0, halted=0. Reset asserted mid-REDIRECT or mid-HALT discards pending redirect and halt.
- HOLD: fetch_en=0. hold_cnt decrements each cycle; at 1 → RUN. Fetch first enabled exactly RESET_HOLD_CYCLES cycles after rst rises. All request inputs are ignored.
- RUN: fetch_en = ~(stall_req | mem_busy); jump=0.
  - branch_taken=1: capture target_q = {branch_target[XLEN-1:2], 2'b00}; next state REDIRECT. flush_ifid and flush_idex are both 1 for exactly the next cycle. Branch wins over stall_req, mem_busy and halt_req in the same cycle.
  - halt_req with branch_taken in the same cycle: set halt_pend; the halt is taken after the redirect completes.
  - halt_req alone: next state HALT.
- REDIRECT: jump=1, jpc=target_q, fetch_en = ~mem_busy.
  - While mem_busy=1, stay in REDIRECT with jump and jpc held.
  - When mem_busy=0 (the jump is taken that cycle), go to HALT if halt_pend, else RUN; clear halt_pend.
  - branch_taken is ignored (the younger branch was flushed). stall_req is ignored (decode is being flushed). halt_req sets halt_pend.
- HALT: fetch_en=0, jump=0, halted=1. resume=1 → RUN next cycle. branch_taken and halt_req are ignored. resume is ignored outside HALT.
- jpc = target_q in all states; it is only meaningful while jump=1.
- stall_cycles: increments on each RUN cycle with fetch_en=0 and saturates at 16'hFFFF. It does not count HOLD, REDIRECT-wait or HALT cycles.

Optional Feature:
FETCH_CTRL_PERF_EN
- Defined: the stall_cycles counter is implemented as described above.
- Undefined: the counter register is not built and stall_cycles is tied to 16'h0000. All other behaviour is identical.

Test Plan:
- Reset release with RESET_HOLD_CYCLES=2, no requests → fetch_en=0 for 2 cycles after rst rises, then 1. All other outputs 0.
- RUN, branch_taken=1 with branch_target=32'h0000_0043 → next cycle jump=1, jpc=32'h0000_0040, fetch_en=1, flush_ifid=flush_idex=1 for one cycle. The cycle after, jump=0.
- RUN, stall_req=1 for 3 cycles → fetch_en=0 for those 3 cycles, stall_cycles increments 0→3 (with FETCH_CTRL_PERF_EN). Tied at 0 without the macro.
- Same cycle branch_taken=1 and halt_req=1, mem_busy=1 for 2 cycles in REDIRECT → jump held for 3 cycles with fetch_en=0,0,1. Then HALT with halted=1; resume → RUN.
- rst driven low asynchronously mid-REDIRECT → outputs go to reset values immediately, before the next clock edge. The pending halt is lost: after the hold period the state is RUN, not HALT.
- Force stall_cycles to 16'hFFFE, then hold stall_req=1 for 4 cycles → stall_cycles=16'hFFFF and holds there (no wrap).
